mio_bus_responder: RTL and testbench

MIO_BUS_RESPONDER -- requirements
Module: mio_bus_responder

---
 rtl/mio_pkg.sv | 32 +++
 rtl/mio_bus_responder_if.sv | 22 ++
 rtl/mio_ram.sv | 30 +++
 rtl/mio_bus_responder.sv | 142 ++++++++++++++
 tb/tb_mio_bus_responder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mio_pkg.sv
// Shared types and address map for the memory-mapped I/O bus responder.
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_SW,
        TGT_LED,
        TGT_TIMER,
        TGT_NONE
    } target_e;

    localparam logic [3:0]  RAM_REGION = 4'h0;
    localparam logic [31:0] SW_ADDR    = 32'hE000_0000;
    localparam logic [31:0] LED_ADDR   = 32'hF000_0000;
    localparam logic [31:0] TIMER_ADDR = 32'hF000_0004;

    // RAM claims the whole low 256 MB region; peripherals match exact addresses.
    function automatic target_e decode(input logic [31:0] a);
        if (a[31:28] == RAM_REGION) return TGT_RAM;
        else if (a == SW_ADDR)      return TGT_SW;
        else if (a == LED_ADDR)     return TGT_LED;
        else if (a == TIMER_ADDR)   return TGT_TIMER;
        else                        return TGT_NONE;
    endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// Request/acknowledge bus between a CPU-side initiator and the responder.
interface mio_bus_responder_if;

    logic        cpu_mio;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        mio_ready;

    modport master (
        output cpu_mio, mem_w, addr, wdata, be,
        input  rdata, mio_ready
    );

    modport slave (
        input  cpu_mio, mem_w, addr, wdata, be,
        output rdata, mio_ready
    );

endinterface

// File: rtl/mio_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
module mio_ram #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [WORDS];

    // NOTE: storage and its read register carry no reset; a reset loop over
    // the array would block RAM inference and contents are undefined anyway.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Bus responder: captures one request, waits WAIT_CYCLES, then acknowledges
// with RAM, switch, LED or timer data.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned RAM_WORDS   = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    mio_bus_responder_if.slave   bus,
    input  logic [15:0]          sw_in,
    output logic [15:0]          led_out
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        enter_ack;

    logic [31:0] rdata_q;
    logic        ram_sel_q;
    logic [15:0] led_q;
    logic [31:0] timer_q;

    target_e     tgt;
    logic        ram_en;
    logic [31:0] ram_rdata;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        enter_ack = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cpu_mio) begin
                    we_d    = bus.mem_w;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    be_d    = bus.be;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The access uses the _d view so a zero-wait accept commits on its own edge.
    assign tgt    = decode(addr_d);
    assign ram_en = enter_ack && (tgt == TGT_RAM);

    mio_ram #(.WORDS(RAM_WORDS)) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (we_d),
        .be_i    (be_d),
        .addr_i  (addr_d[AW+1:2]),
        .wdata_i (wdata_d),
        .rdata_o (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q   <= '0;
            ram_sel_q <= 1'b0;
            led_q     <= '0;
            timer_q   <= '0;
        end else begin
            if (enter_ack && we_d && (tgt == TGT_TIMER)) timer_q <= wdata_d;
            else                                         timer_q <= timer_q + 32'd1;

            if (enter_ack && we_d && (tgt == TGT_LED)) begin
                if (be_d[0]) led_q[7:0]  <= wdata_d[7:0];
                if (be_d[1]) led_q[15:8] <= wdata_d[15:8];
            end

            ram_sel_q <= enter_ack && !we_d && (tgt == TGT_RAM);
            rdata_q   <= '0;
            if (enter_ack && !we_d) begin
                unique case (tgt)
                    TGT_SW:    rdata_q <= {16'h0, sw_in};
                    TGT_LED:   rdata_q <= {16'h0, led_q};
                    TGT_TIMER: rdata_q <= timer_q;
                    default:   rdata_q <= '0;
                endcase
            end
        end
    end

    assign bus.mio_ready = (state_q == ST_ACK);
    assign bus.rdata     = (state_q != ST_ACK) ? 32'h0 :
                           ram_sel_q           ? ram_rdata : rdata_q;
    assign led_out       = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed self-checking bench: one responder with two wait states, one with none.
module tb_mio_bus_responder;
    import mio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw_in = 16'hBEEF;
    logic [15:0] led2, led0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    mio_bus_responder_if bus2 ();
    mio_bus_responder_if bus0 ();

    mio_bus_responder #(.WAIT_CYCLES(2), .RAM_WORDS(256)) dut2 (
        .clk     (clk),
        .reset   (rst),
        .bus     (bus2),
        .sw_in   (sw_in),
        .led_out (led2)
    );

    mio_bus_responder #(.WAIT_CYCLES(0), .RAM_WORDS(256)) dut0 (
        .clk     (clk),
        .reset   (rst),
        .bus     (bus0),
        .sw_in   (sw_in),
        .led_out (led0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with dut2 idle; scrambles the live inputs while
    // waiting so only captured values can produce the right answer.
    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output int lat);
        bus2.cpu_mio = 1'b1;
        bus2.mem_w   = we;
        bus2.addr    = a;
        bus2.wdata   = d;
        bus2.be      = b;
        rd  = '0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus2.mio_ready) begin
                lat = i;
                rd  = bus2.rdata;
                break;
            end
            bus2.mem_w = ~we;
            bus2.addr  = ~a;
            bus2.wdata = ~d;
            bus2.be    = ~b;
        end
        bus2.cpu_mio = 1'b0;
        bus2.mem_w   = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    int          lat;
    logic        seen_ready;

    initial begin
        bus2.cpu_mio = 0; bus2.mem_w = 0; bus2.addr = 0; bus2.wdata = 0; bus2.be = 0;
        bus0.cpu_mio = 0; bus0.mem_w = 0; bus0.addr = 0; bus0.wdata = 0; bus0.be = 0;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(bus2.mio_ready), 32'd0);
        check("rst_rdata", bus2.rdata, 32'd0);
        check("rst_led",   32'(led2), 32'd0);
        check("rst_timer", dut2.timer_q, 32'd0);
        check("rst_state", 32'(dut2.state_q), 32'(ST_IDLE));
        check("rst_addr",  dut2.addr_q, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, rd, lat);
        check("wr_latency", 32'(lat), 32'd3);
        xfer(1'b0, 32'h0000_0010, 32'h0, 4'b0000, rd, lat);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_ram10", rd, 32'h1234_5678);
        check("rdata_idle_zero", bus2.rdata, 32'd0);
        xfer(1'b0, 32'h0000_0410, 32'h0, 4'b0000, rd, lat);
        check("rd_alias", rd, 32'h1234_5678);
        xfer(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, rd, lat);
        check("be0_ack", 32'(lat), 32'd3);
        xfer(1'b0, 32'h0000_0010, 32'h0, 4'b0000, rd, lat);
        check("be0_noop", rd, 32'h1234_5678);

        xfer(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b1111, rd, lat);
        xfer(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, rd, lat);
        xfer(1'b0, 32'h0000_0020, 32'h0, 4'b0000, rd, lat);
        check("rd_partial", rd, 32'h12BB_56DD);

        xfer(1'b1, 32'hF000_0000, 32'h0000_A5C3, 4'b0001, rd, lat);
        check("led_lo", 32'(led2), 32'h0000_00C3);
        xfer(1'b1, 32'hF000_0000, 32'h0000_7700, 4'b0010, rd, lat);
        check("led_hi", 32'(led2), 32'h0000_77C3);
        xfer(1'b0, 32'hF000_0000, 32'h0, 4'b0000, rd, lat);
        check("rd_led", rd, 32'h0000_77C3);
        xfer(1'b0, 32'hE000_0000, 32'h0, 4'b0000, rd, lat);
        check("rd_sw", rd, 32'h0000_BEEF);
        xfer(1'b1, 32'hE000_0000, 32'h1111_1111, 4'b1111, rd, lat);
        check("sw_wr_ack", 32'(lat), 32'd3);
        xfer(1'b0, 32'hE000_0000, 32'h0, 4'b0000, rd, lat);
        check("sw_wr_ignored", rd, 32'h0000_BEEF);
        xfer(1'b1, 32'h8000_0000, 32'h5555_5555, 4'b1111, rd, lat);
        check("unmap_wr_ack", 32'(lat), 32'd3);
        xfer(1'b0, 32'h8000_0000, 32'h0, 4'b0000, rd, lat);
        check("unmap_rd", rd, 32'd0);
        check("unmap_rd_lat", 32'(lat), 32'd3);

        // Timer holds FFFF_FFFE in ACK, FFFF_FFFF one cycle later, then wraps.
        xfer(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 4'b0000, rd, lat);
        check("timer_preload", dut2.timer_q, 32'hFFFF_FFFF);
        xfer(1'b0, 32'hF000_0004, 32'h0, 4'b0000, rd, lat);
        check("timer_wrapped", rd, 32'h0000_0001);

        xfer(1'b1, 32'h0000_0004, 32'h1111_1111, 4'b1111, rd, lat);
        bus2.cpu_mio = 1'b1;
        bus2.mem_w   = 1'b1;
        bus2.addr    = 32'h0000_0004;
        bus2.wdata   = 32'h2222_2222;
        bus2.be      = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        check("pre_abort_state", 32'(dut2.state_q), 32'(ST_WAIT));
        rst = 1'b0;
        bus2.cpu_mio = 1'b0;
        bus2.mem_w   = 1'b0;
        #1;
        check("abort_state", 32'(dut2.state_q), 32'(ST_IDLE));
        check("abort_led", 32'(led2), 32'd0);
        check("abort_cnt", 32'(dut2.cnt_q), 32'd0);
        seen_ready = bus2.mio_ready;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen_ready = seen_ready | bus2.mio_ready;
        end
        check("abort_no_ready", 32'(seen_ready), 32'd0);
        xfer(1'b0, 32'h0000_0004, 32'h0, 4'b0000, rd, lat);
        check("abort_no_commit", rd, 32'h1111_1111);

        bus0.cpu_mio = 1'b1;
        bus0.mem_w   = 1'b0;
        bus0.addr    = 32'hE000_0000;
        @(negedge clk);
        check("w0_ready_c1", 32'(bus0.mio_ready), 32'd1);
        check("w0_rd_sw", bus0.rdata, 32'h0000_BEEF);
        bus0.addr = 32'h8000_0000;
        @(negedge clk);
        check("w0_ready_c2", 32'(bus0.mio_ready), 32'd0);
        @(negedge clk);
        check("w0_ready_c3", 32'(bus0.mio_ready), 32'd1);
        check("w0_rd_unmap", bus0.rdata, 32'd0);
        bus0.cpu_mio = 1'b0;
        @(negedge clk);
        check("w0_ready_c4", 32'(bus0.mio_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
